// File: rtl/hex_sseg_scan.sv
// Time-multiplexed hex driver for a common-anode seven-segment display, with double-buffered input.
// Optional macro LEADING_ZERO_BLANK_EN: darken leading zero digits of the displayed value.
module hex_sseg_scan #(
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 12000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hexIn,
    input  logic [DIGITS-1:0]     dpIn,
    input  logic [DIGITS-1:0]     blankIn,
    output logic [7:0]            sseg,
    output logic [DIGITS-1:0]     an,
    output logic                  frameTick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] hex;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
    } frame_t;

    logic [CNT_W-1:0] prescaler;
    logic [IDX_W-1:0] idx;
    logic             wrap;
    logic             boundary;
    logic             pending;
    frame_t           in_frame;
    frame_t           shadow;
    frame_t           disp;

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic logic [6:0] dec(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

    assign in_frame = '{hex: hexIn, dp: dpIn, blank: blankIn};
    assign wrap     = (prescaler == PRE_LAST);
    assign boundary = wrap && (idx == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (wrap) begin
            prescaler <= '0;
            idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    // A load on the boundary cycle bypasses the shadow so it lands in the very next frame.
    // NOTE: shadow and display are plain registers, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else if (load) begin
            if (boundary) begin
                disp    <= in_frame;
                pending <= 1'b0;
            end else begin
                shadow  <= in_frame;
                pending <= 1'b1;
            end
        end else if (boundary && pending) begin
            disp    <= shadow;
            pending <= 1'b0;
        end
    end

    logic [DIGITS-1:0] lz_dark;

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_run;

    always_comb begin
        lz_dark = '0;
        lz_run  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lz_run && (disp.hex[4*k +: 4] == 4'h0) && !disp.dp[k]) begin
                lz_dark[k] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end
`else
    assign lz_dark = '0;
`endif

    logic [DIGITS-1:0]   dark;
    logic [DIGITS-1:0]   dp_sh;
    logic [DIGITS-1:0]   dark_sh;
    logic [4*DIGITS-1:0] hex_sh;
    logic [7:0]          sseg_nxt;
    logic [DIGITS-1:0]   an_nxt;

    assign dark    = disp.blank | lz_dark;
    assign dp_sh   = disp.dp >> idx;
    assign dark_sh = dark >> idx;
    assign hex_sh  = disp.hex >> {idx, 2'b00};

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        sseg_nxt = 8'hFF;
        an_nxt   = '1;
        if ((prescaler != '0) && !dark_sh[0]) begin
            an_nxt   = ~(DIGITS'(1) << idx);
            sseg_nxt = {~dp_sh[0], dec(hex_sh[3:0])};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sseg      <= 8'hFF;
            an        <= '1;
            frameTick <= 1'b0;
        end else begin
            sseg      <= sseg_nxt;
            an        <= an_nxt;
            frameTick <= boundary;
        end
    end

endmodule

// File: tb/tb_hex_sseg_scan.sv
// Scoreboard bench for hex_sseg_scan: a time-indexed reference model predicts every output cycle.
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_hex_sseg_scan;

    localparam int D  = 3;
    localparam int R  = 4;
    localparam int FR = D * R;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           load = 1'b0;
    logic [4*D-1:0] hex_in = '0;
    logic [D-1:0]   dp_in = '0;
    logic [D-1:0]   blank_in = '0;
    logic [7:0]     sseg;
    logic [D-1:0]   an;
    logic           frame_tick;

    hex_sseg_scan #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .hexIn     (hex_in),
        .dpIn      (dp_in),
        .blankIn   (blank_in),
        .sseg      (sseg),
        .an        (an),
        .frameTick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   sseg;
        logic [D-1:0] an;
        logic         ft;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since reset release give prescaler phase and digit directly.
    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    int             m_n;
    bit             in_rst;
    bit             m_pend;
    logic [4*D-1:0] m_hex, s_hex;
    logic [D-1:0]   m_dp, m_blank, s_dp, s_blank;

    function automatic bit digit_dark(input int k);
        int top;
        if (m_blank[k]) return 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        top = 0;
        for (int j = 0; j < D; j++)
            if ((4'(m_hex >> (4*j)) != 4'h0) || m_dp[j]) top = j;
        return k > top;
`else
        top = k;
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        m_n = 0; m_pend = 0;
        m_hex = '0; m_dp = '0; m_blank = '0;
        s_hex = '0; s_dp = '0; s_blank = '0;
    endtask

    task automatic model_step(input bit l, input logic [4*D-1:0] h, input logic [D-1:0] d,
                              input logic [D-1:0] b);
        exp_t       e;
        int         p, i;
        bit         bnd;
        logic [3:0] nib;
        p   = m_n % R;
        i   = (m_n / R) % D;
        bnd = (p == R-1) && (i == D-1);
        e.sseg = 8'hFF; e.an = '1; e.ft = 1'b0;
        if (!in_rst) begin
            e.ft = bnd;
            if (p != 0 && !digit_dark(i)) begin
                nib    = 4'(m_hex >> (4*i));
                e.an   = ~(D'(1) << i);
                e.sseg = {~m_dp[i], seg_tab[nib]};
            end
            if (l && bnd) begin
                m_hex = h; m_dp = d; m_blank = b; m_pend = 0;
            end else if (l) begin
                s_hex = h; s_dp = d; s_blank = b; m_pend = 1;
            end else if (bnd && m_pend) begin
                m_hex = s_hex; m_dp = s_dp; m_blank = s_blank; m_pend = 0;
            end
            m_n++;
        end
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_sseg", sseg, e.sseg);
                check("sb_an", an, e.an);
                check("sb_ft", frame_tick, e.ft);
            end
        end
    end

    task automatic cycle(input bit l, input logic [4*D-1:0] h, input logic [D-1:0] d,
                         input logic [D-1:0] b);
        @(negedge clk);
        load = l; hex_in = h; dp_in = d; blank_in = b;
        model_step(l, h, d, b);
    endtask

    // Idle cycles drive junk on the data inputs; with load low it must be ignored.
    task automatic cycle_idle();
        cycle(1'b0, (4*D)'($urandom), D'($urandom), D'($urandom));
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clk);
        reset_n = 1'b0; load = 1'b0; in_rst = 1'b1;
        model_clear();
        #1;
        check("async_rst_sseg", sseg, 8'hFF);
        check("async_rst_an", an, {D{1'b1}});
        check("async_rst_ft", frame_tick, 1'b0);
        model_step(1'b0, '0, '0, '0);
        repeat (cyc - 1) begin
            @(negedge clk);
            model_step(1'b0, '0, '0, '0);
        end
        @(negedge clk);
        reset_n = 1'b1; in_rst = 1'b0;
        model_step(1'b0, '0, '0, '0);
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            cycle_idle();
            k++;
        end while (frame_tick !== 1'b1 && k < 3*FR);
        check("wait_frame", frame_tick, 1'b1);
    endtask

    task automatic goto_phase(input int ph);
        while (m_n % FR != ph) cycle_idle();
    endtask

    // Starts on the frameTick cycle; checks every cycle of the following frame against constants.
    task automatic frame_body(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [D-1:0] dark);
        logic [7:0]   sx;
        logic [D-1:0] ax;
        for (int d = 0; d < D; d++) begin
            sx = (d == 0) ? s0 : (d == 1) ? s1 : s2;
            for (int c = 0; c < R; c++) begin
                cycle_idle();
                ax = (c == 0 || dark[d]) ? {D{1'b1}} : ~(D'(1) << d);
                check($sformatf("%s_d%0d_c%0d_an", tag, d, c), an, ax);
                check($sformatf("%s_d%0d_c%0d_sseg", tag, d, c), sseg,
                      (c == 0 || dark[d]) ? 8'hFF : sx);
            end
        end
    endtask

    initial begin : stimulus
        int edges;
        model_clear();
        in_rst = 1'b1;

        // Reset with clock running, then first-dwell and first-frameTick timing.
        do_reset(4);
        cycle_idle();
        check("t1_gap_an", an, 3'b111);
        cycle_idle();
        check("t1_dig0_an", an, 3'b110);
        edges = 2;
        while (frame_tick !== 1'b1 && edges < 50) begin
            cycle_idle();
            edges++;
        end
        check("t1_first_ft_edge", edges, 3*R);

        // Decode and decimal point per digit.
        cycle(1'b1, 12'h3A7, 3'b010, 3'b000);
        wait_frame();
        frame_body("t2", 8'h8F, 8'h08, 8'h86, 3'b000);

        // Two loads in one frame: only the last appears, and only from the boundary.
        goto_phase(2);
        cycle(1'b1, 12'h111, 3'b000, 3'b000);
        cycle_idle();
        cycle_idle();
        cycle(1'b1, 12'h222, 3'b000, 3'b000);
        wait_frame();
        frame_body("t3", 8'h92, 8'h92, 8'h92, 3'b000);

        // Load on the boundary cycle itself goes straight to display.
        goto_phase(FR - 1);
        cycle(1'b1, 12'h456, 3'b000, 3'b000);
        cycle_idle();
        check("t3_bnd_ft", frame_tick, 1'b1);
        frame_body("t3b", 8'hA0, 8'hA4, 8'hCC, 3'b000);

        // Per-digit blank.
        cycle(1'b1, 12'h888, 3'b000, 3'b100);
        wait_frame();
        frame_body("t4", 8'h80, 8'h80, 8'h80, 3'b100);

        // Leading zeros, with and without a decimal point stopping suppression.
        cycle(1'b1, 12'h005, 3'b000, 3'b000);
        wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
        frame_body("t5", 8'hA4, 8'h81, 8'h81, 3'b110);
`else
        frame_body("t5", 8'hA4, 8'h81, 8'h81, 3'b000);
`endif
        cycle(1'b1, 12'h005, 3'b010, 3'b000);
        wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
        frame_body("t5dp", 8'hA4, 8'h01, 8'h81, 3'b100);
`else
        frame_body("t5dp", 8'hA4, 8'h01, 8'h81, 3'b000);
`endif

        // Randomized traffic, with a mid-frame reset that must drop a pending load.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                goto_phase(5);
                cycle(1'b1, 12'hFED, 3'b111, 3'b000);
                do_reset(2);
            end else if ($urandom_range(5) == 0) begin
                cycle(1'b1, (4*D)'($urandom), D'($urandom), D'($urandom));
            end else begin
                cycle_idle();
            end
        end

        for (int k = 0; k < 4 && sb_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        check("sb_drain", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
